// File: rtl/axis_stat_pkg.sv
// axis_stat_pkg: shared record geometry and receiver state for the statistics stream.
package axis_stat_pkg;
  typedef enum logic {RECV, DROP} state_t;
  function automatic int field_bytes(input int w);
    return (w + 7) / 8;
  endfunction
  function automatic int rec_len(input int tw, input int kw, input int bw, input int fw);
    return field_bytes(tw) + field_bytes(kw) + field_bytes(bw) + field_bytes(fw);
  endfunction
  localparam int DEF_TAG_BYTES = field_bytes(16);
  localparam int DEF_COUNT_BYTES = field_bytes(32);
  localparam int DEF_REC_LEN = rec_len(16, 32, 32, 32);
endpackage

// File: rtl/axis_stat_acc.sv
// axis_stat_acc: running byte/frame totals, advanced on each committed record.
module axis_stat_acc #(
  parameter int BYTE_COUNT_WIDTH = 32,
  parameter int FRAME_COUNT_WIDTH = 32,
  parameter int ACC_WIDTH = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         commit,
  input  logic [BYTE_COUNT_WIDTH-1:0]  byte_count,
  input  logic [FRAME_COUNT_WIDTH-1:0] frame_count,
  output logic [ACC_WIDTH-1:0]         acc_byte_count,
  output logic [ACC_WIDTH-1:0]         acc_frame_count
);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      acc_byte_count <= '0;
      acc_frame_count <= '0;
    end else if (commit) begin
      acc_byte_count <= acc_byte_count + ACC_WIDTH'(byte_count);
      acc_frame_count <= acc_frame_count + ACC_WIDTH'(frame_count);
    end
endmodule

// File: rtl/axis_stat_unpack.sv
// axis_stat_unpack: reassembles statistics records from an 8-bit AXI stream.
// Optional running totals enabled by AXIS_STAT_UNPACK_ACC_EN.
module axis_stat_unpack import axis_stat_pkg::*; #(
  parameter int TAG_WIDTH = 16,
  parameter int TICK_COUNT_WIDTH = 32,
  parameter int BYTE_COUNT_WIDTH = 32,
  parameter int FRAME_COUNT_WIDTH = 32,
  parameter int ACC_WIDTH = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   s_axis_tdata,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  input  logic                         s_axis_tlast,
  input  logic                         s_axis_tuser,
  output logic [TAG_WIDTH-1:0]         out_tag,
  output logic [TICK_COUNT_WIDTH-1:0]  out_tick_count,
  output logic [BYTE_COUNT_WIDTH-1:0]  out_byte_count,
  output logic [FRAME_COUNT_WIDTH-1:0] out_frame_count,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ACC_WIDTH-1:0]         acc_byte_count,
  output logic [ACC_WIDTH-1:0]         acc_frame_count,
  output logic                         err_short,
  output logic                         err_long,
  output logic                         err_user,
  output logic [15:0]                  err_count
);
  localparam int TB = field_bytes(TAG_WIDTH);
  localparam int KB = field_bytes(TICK_COUNT_WIDTH);
  localparam int BB = field_bytes(BYTE_COUNT_WIDTH);
  localparam int FB = field_bytes(FRAME_COUNT_WIDTH);
  localparam int L = rec_len(TAG_WIDTH, TICK_COUNT_WIDTH, BYTE_COUNT_WIDTH, FRAME_COUNT_WIDTH);
  localparam int RW = 8 * L;
  localparam int PW = $clog2(L + 1);
  localparam logic [PW-1:0] LAST = PW'(L - 1);
  state_t state, state_next;
  logic [PW-1:0] ptr;
  logic [RW-9:0] stage;
  logic [RW-1:0] rec;
  logic accept, last, commit, e_short, e_long, e_user;
  logic [TAG_WIDTH-1:0] tag_new;
  logic [TICK_COUNT_WIDTH-1:0] tick_new;
  logic [BYTE_COUNT_WIDTH-1:0] byte_new;
  logic [FRAME_COUNT_WIDTH-1:0] frame_new;
  // Only the committing byte stalls, and only while the previous record is unclaimed.
  assign s_axis_tready = !(state == RECV && ptr == LAST && out_valid && !out_ready);
  assign accept = s_axis_tvalid && s_axis_tready;
  assign last = ptr == LAST;
  assign rec = {stage, s_axis_tdata};
  assign tag_new = TAG_WIDTH'(rec[RW-1 -: 8*TB]);
  assign tick_new = TICK_COUNT_WIDTH'(rec[RW-8*TB-1 -: 8*KB]);
  assign byte_new = BYTE_COUNT_WIDTH'(rec[8*(BB+FB)-1 -: 8*BB]);
  assign frame_new = FRAME_COUNT_WIDTH'(rec[8*FB-1:0]);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= RECV;
    else state <= state_next;
  always_comb
    state_next = state == RECV ? (accept && last && !s_axis_tlast ? DROP : RECV)
                               : (accept && s_axis_tlast ? RECV : DROP);
  always_comb begin
    commit = accept && state == RECV && last && s_axis_tlast && !s_axis_tuser;
    e_short = accept && state == RECV && !last && s_axis_tlast;
    e_user = accept && state == RECV && last && s_axis_tlast && s_axis_tuser;
    e_long = accept && state == DROP && s_axis_tlast;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ptr <= '0;
      stage <= '0;
      out_tag <= '0;
      out_tick_count <= '0;
      out_byte_count <= '0;
      out_frame_count <= '0;
      out_valid <= 1'b0;
      err_short <= 1'b0;
      err_long <= 1'b0;
      err_user <= 1'b0;
      err_count <= '0;
    end else begin
      err_short <= e_short;
      err_long <= e_long;
      err_user <= e_user;
      if (e_short || e_long || e_user) err_count <= err_count == 16'hFFFF ? err_count : err_count + 16'd1;
      if (accept) begin
        ptr <= state == RECV && !s_axis_tlast && !last ? ptr + PW'(1) : '0;
        stage <= rec[RW-9:0];
      end
      if (commit) begin
        out_tag <= tag_new;
        out_tick_count <= tick_new;
        out_byte_count <= byte_new;
        out_frame_count <= frame_new;
      end
      out_valid <= commit || (out_valid && !out_ready);
    end
`ifdef AXIS_STAT_UNPACK_ACC_EN
  axis_stat_acc #(
    .BYTE_COUNT_WIDTH(BYTE_COUNT_WIDTH),
    .FRAME_COUNT_WIDTH(FRAME_COUNT_WIDTH),
    .ACC_WIDTH(ACC_WIDTH)
  ) u_acc (
    .clk(clk),
    .rst(rst),
    .commit(commit),
    .byte_count(byte_new),
    .frame_count(frame_new),
    .acc_byte_count(acc_byte_count),
    .acc_frame_count(acc_frame_count)
  );
`else
  assign acc_byte_count = '0;
  assign acc_frame_count = '0;
`endif
endmodule
